// File: rtl/hash_unit_fnv_if.sv
// Handshake/data bundle between the issue logic and the FNV-1a hash unit.
// The master side issues operands; the slave side (the unit) returns status and the hash.
interface hash_unit_fnv_if #(
  parameter int N = 32
);
  logic         start;
  logic         abort;
  logic [N-1:0] data_in;
  logic         use_seed;
  logic [31:0]  seed_in;
  logic         busy;
  logic         stall;
  logic         done;
  logic [31:0]  hash_out;

  modport master (
    output start, abort, data_in, use_seed, seed_in,
    input  busy, stall, done, hash_out
  );

  modport slave (
    input  start, abort, data_in, use_seed, seed_in,
    output busy, stall, done, hash_out
  );
endinterface

// File: rtl/hash_unit_fnv.sv
// Multi-cycle FNV-1a hash unit: folds an N-bit operand into a 32-bit hash,
// one byte per clock, least-significant byte first.
module hash_unit_fnv #(
  parameter int          N      = 32,
  parameter logic [31:0] OFFSET = 32'h811C9DC5,
  parameter logic [31:0] PRIME  = 32'h01000193
) (
  input logic            clk,
  input logic            rst_n,
  hash_unit_fnv_if.slave bus
);

  localparam int BYTES = N / 8;
  localparam int CNT_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [N-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hash_q, hash_d;

  logic [31:0] mix;
  logic [31:0] step;
  logic        accept;

  // One FNV-1a round on the current low byte; the product keeps only its low 32 bits.
  assign mix    = acc_q ^ {24'b0, sh_q[7:0]};
  assign step   = mix * PRIME;

  // IDLE and DONE both accept a new operand; Abort blocks acceptance.
  assign accept = (state_q != RUN) && bus.start && !bus.abort;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    hash_d  = hash_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          sh_d    = bus.data_in;
          acc_d   = bus.use_seed ? bus.seed_in : OFFSET;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            hash_d  = step;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      hash_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.stall    = bus.start && (state_q == RUN);
  assign bus.hash_out = hash_q;

endmodule
